axi_mem_master: RTL and testbench

AXI_MEM_MASTER -- requirements
Module: axi_mem_master

---
 rtl/axi_mem_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_mem_master.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_master.sv
// axi_mem_master: turns single front-end requests into AXI4 transactions.
// One transaction is outstanding at a time: reads are issued as a single
// INCR burst of req_len+1 beats and writes as a single-beat INCR burst.
// Every read beat is forwarded to the response port combinationally in the
// R handshake cycle; a write produces one response when its B beat arrives.
//
// Handshake rule, used on the front end and on every AXI channel: a
// transfer happens on a rising clock edge where valid and ready are both 1.
// A valid, once raised, is held with stable payload until that transfer.
//
// reset is synchronous and active low. While it is low every valid/ready
// output is forced to 0 combinationally, so an abandoned transaction never
// produces a response pulse and never completes a handshake.
module axi_mem_master #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clock,
  input  logic        reset,

  // Front-end request port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [7:0]  req_len,

  // Front-end response port
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_last,
  output logic        resp_err,

  // AXI4 write address channel
  input  logic        io_master_awready,
  output logic        io_master_awvalid,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,

  // AXI4 write data channel
  input  logic        io_master_wready,
  output logic        io_master_wvalid,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,

  // AXI4 write response channel
  output logic        io_master_bready,
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,

  // AXI4 read address channel
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,

  // AXI4 read data channel
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [31:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,

  // Current FSM state, for monitors and debug
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WADDR = 3'd3,
    S_WRESP = 3'd4
  } state_t;

  localparam logic [2:0] AXSIZE_4B = 3'b010;
  localparam logic [1:0] BURST_INC = 2'b01;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        accept;
  logic        beat_at_len;
  logic        aw_fire;
  logic        w_fire;

  // The beat counter reaching the requested length marks the expected last beat.
  assign beat_at_len = (cnt_q == len_q);
  assign aw_fire     = !aw_done_q && io_master_awready;
  assign w_fire      = !w_done_q && io_master_wready;

  // Request payload is captured at acceptance and only changes at the next
  // acceptance, which keeps every AR/AW/W field stable while its valid is up.
  // The transfer direction is recorded by the state the FSM moves into.
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = AXSIZE_4B;
  assign io_master_arburst = BURST_INC;

  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = AXSIZE_4B;
  assign io_master_awburst = BURST_INC;

  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_wlast   = 1'b1;

  assign state_dbg = state_q;

  // State register, beat counter, write-handshake flags and request capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      len_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        len_q   <= req_len;
      end
    end
  end

  // Next-state logic and all handshake/response outputs, forced idle in reset.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    aw_done_d         = aw_done_q;
    w_done_d          = w_done_q;
    accept            = 1'b0;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    resp_rdata        = 32'd0;
    resp_last         = 1'b0;
    resp_err          = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;

    if (reset) begin
      unique case (state_q)
        S_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            accept    = 1'b1;
            cnt_d     = 8'd0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = req_wen ? S_WADDR : S_RADDR;
          end
        end

        S_RADDR: begin
          io_master_arvalid = 1'b1;
          if (io_master_arready) begin
            state_d = S_RDATA;
          end
        end

        S_RDATA: begin
          io_master_rready = 1'b1;
          if (io_master_rvalid) begin
            resp_valid = 1'b1;
            resp_rdata = io_master_rdata;
            // The burst ends at the slave's rlast or at the requested length,
            // whichever comes first; disagreement between the two is an error.
            resp_last  = io_master_rlast || beat_at_len;
            resp_err   = (io_master_rresp != 2'b00) ||
                         (io_master_rid != AXI_ID) ||
                         (io_master_rlast != beat_at_len);
            cnt_d      = cnt_q + 8'd1;
            if (io_master_rlast || beat_at_len) begin
              state_d = S_IDLE;
            end
          end
        end

        S_WADDR: begin
          // AW and W are independent channels: each valid drops after its own
          // transfer and the FSM waits until both have completed.
          io_master_awvalid = !aw_done_q;
          io_master_wvalid  = !w_done_q;
          if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WRESP;
          end else begin
            aw_done_d = aw_done_q || aw_fire;
            w_done_d  = w_done_q || w_fire;
          end
        end

        S_WRESP: begin
          io_master_bready = 1'b1;
          if (io_master_bvalid) begin
            resp_valid = 1'b1;
            resp_last  = 1'b1;
            resp_err   = (io_master_bresp != 2'b00) || (io_master_bid != AXI_ID);
            state_d    = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed and randomized bench for axi_mem_master. The bench plays the AXI
// slave, predicts every response pulse from the transaction rules and checks
// the observed pulses, channel fields and handshake timing against that.
module tb_axi_mem_master;

  localparam logic [3:0] ID = 4'h3;
  localparam int MAXB    = 16;
  localparam int TIMEOUT = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic [7:0]  req_len = 8'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_last;
  logic        resp_err;
  logic        awready = 1'b0;
  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wready = 1'b0;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bready;
  logic        bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic [3:0]  bid = 4'd0;
  logic        arready = 1'b0;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready;
  logic        rvalid = 1'b0;
  logic [1:0]  rresp = 2'b00;
  logic [31:0] rdata = 32'd0;
  logic        rlast = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [2:0]  state_dbg;

  always #5 clock = ~clock;

  axi_mem_master #(.AXI_ID(ID)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_len(req_len),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_last(resp_last), .resp_err(resp_err),
    .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wready(wready), .io_master_wvalid(wvalid), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
    .io_master_bid(bid),
    .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid),
    .state_dbg(state_dbg)
  );

  // Scoreboard: expected and observed responses as {rdata, last, err}
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  int          obs_rd = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  int cyc = 0;
  int done_cyc = -1;
  int acc_cyc = -1;
  int overlap_cnt = 0;

  // Slave beat table for the next read
  logic [31:0] bt_data[MAXB];
  logic        bt_last[MAXB];
  logic [1:0]  bt_resp[MAXB];
  logic [3:0]  bt_id[MAXB];

  // Response and timing monitor, sampled mid-cycle
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (resp_valid) begin
      obs_q.push_back({resp_rdata, resp_last, resp_err});
      if (resp_last) done_cyc = cyc;
    end
    if (req_valid && req_ready) acc_cyc = cyc;
    if (arvalid && awvalid) overlap_cnt = overlap_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_beats();
    for (int i = 0; i < MAXB; i++) begin
      bt_data[i] = 32'd0;
      bt_last[i] = 1'b0;
      bt_resp[i] = 2'b00;
      bt_id[i]   = ID;
    end
  endtask

  // Reference read model: a beat ends the burst if the slave marks it last or
  // it is beat number len; it is in error if the response is not OKAY, the ID
  // is foreign, or the slave's last marker disagrees with the requested length.
  function automatic int model_read(input int len);
    logic at_len, fin, err;
    for (int i = 0; i < MAXB; i++) begin
      at_len = (i == len);
      fin    = bt_last[i] || at_len;
      err    = (bt_resp[i] != 2'b00) || (bt_id[i] != ID) || (bt_last[i] != at_len);
      exp_q.push_back({bt_data[i], fin, err});
      if (fin) return i + 1;
    end
    return MAXB;
  endfunction

  task automatic compare_resps(input string tag);
    int n_obs;
    n_obs = obs_q.size() - obs_rd;
    check({tag, "_count"}, n_obs, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_obs; i++)
      check({tag, "_beat"}, obs_q[obs_rd + i], exp_q[i]);
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  task automatic accept_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [7:0] len, input logic keep);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    req_len   = len;
    @(negedge clock);
    while (!req_ready && t < TIMEOUT) begin
      step();
      @(negedge clock);
      t++;
    end
    check("req_accept_in_time", (t < TIMEOUT), 1);
    step();
    req_valid = keep;
  endtask

  task automatic serve_read(input logic [31:0] addr, input logic [7:0] len, input int ard,
                            input int n_send, input int maxgap);
    for (int k = 0; k <= ard; k++) begin
      arready = (k == ard);
      @(negedge clock);
      check("arvalid", arvalid, 1);
      check("araddr", araddr, addr);
      check("arlen", arlen, len);
      if (k == 0) begin
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);
        check("arid", arid, ID);
        check("rready_in_raddr", rready, 0);
      end
      step();
    end
    arready = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      repeat ($urandom_range(0, maxgap)) step();
      rvalid = 1'b1;
      rdata  = bt_data[i];
      rlast  = bt_last[i];
      rresp  = bt_resp[i];
      rid    = bt_id[i];
      @(negedge clock);
      check("rready", rready, 1);
      step();
      rvalid = 1'b0;
    end
  endtask

  task automatic serve_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                             input int daw, input int dw, input int bd,
                             input logic [1:0] br, input logic [3:0] b_id);
    int  aw_hi, w_hi, c;
    logic aw_seen, w_seen;
    aw_hi = 0; w_hi = 0; c = 0; aw_seen = 0; w_seen = 0;
    while (!(aw_seen && w_seen) && c < TIMEOUT) begin
      awready = (c >= daw) && !aw_seen;
      wready  = (c >= dw) && !w_seen;
      @(negedge clock);
      if (c == 0) begin
        check("awvalid", awvalid, 1);
        check("wvalid", wvalid, 1);
        check("awaddr", awaddr, addr);
        check("awlen", awlen, 0);
        check("awsize", awsize, 3'b010);
        check("awburst", awburst, 2'b01);
        check("awid", awid, ID);
        check("wdata", wdata, wd);
        check("wstrb", wstrb, ws);
        check("wlast", wlast, 1);
      end
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (awvalid && awready) aw_seen = 1;
      if (wvalid && wready) w_seen = 1;
      step();
      c++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    check("write_addr_data_done", (c < TIMEOUT), 1);
    check("awvalid_cycles", aw_hi, daw + 1);
    check("wvalid_cycles", w_hi, dw + 1);
    for (int k = 0; k < bd; k++) begin
      @(negedge clock);
      check("bready_wait", bready, 1);
      step();
    end
    bvalid = 1'b1;
    bresp  = br;
    bid    = b_id;
    @(negedge clock);
    check("bready", bready, 1);
    step();
    bvalid = 1'b0;
    exp_q.push_back({32'd0, 1'b1, (br != 2'b00) || (b_id != ID)});
  endtask

  // First cycle after a completion: idle, ready for the next request
  task automatic check_idle(input string tag);
    @(negedge clock);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rready"}, rready, 0);
    check({tag, "_bready"}, bready, 0);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    step();
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input int maxgap);
    int n;
    n = model_read(len);
    accept_req(1'b0, addr, 32'd0, 4'd0, len, 1'b0);
    serve_read(addr, len, $urandom_range(0, 2), n, maxgap);
    check_idle(tag);
    compare_resps(tag);
  endtask

  initial begin
    int len, n, rd_done, wr_acc;
    logic [1:0] br;
    logic [3:0] b_id;

    // Reset: everything quiet, req_ready low while reset is held
    repeat (3) begin
      @(negedge clock);
      check("rst_req_ready", req_ready, 0);
      check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 6'd0);
      step();
    end
    reset = 1'b1;
    @(negedge clock);
    check("rel_req_ready", req_ready, 1);
    step();

    // Single-beat read
    clear_beats();
    bt_data[0] = 32'hDEADBEEF;
    bt_last[0] = 1'b1;
    do_read("read_single", 32'h8000_0000, 8'd0, 0);

    // Four-beat burst with gaps between beats
    clear_beats();
    bt_data[0] = 32'h11; bt_data[1] = 32'h22; bt_data[2] = 32'h33; bt_data[3] = 32'h44;
    bt_last[3] = 1'b1;
    do_read("read_burst", 32'h8000_0040, 8'd3, 3);

    // Write: awready two cycles late, wready immediate
    accept_req(1'b1, 32'h8000_0100, 32'hA5A5A5A5, 4'b0011, 8'd0, 1'b0);
    serve_write(32'h8000_0100, 32'hA5A5A5A5, 4'b0011, 2, 0, $urandom_range(0, 3), 2'b00, ID);
    check_idle("write");
    compare_resps("write");

    // Error responses
    clear_beats();
    bt_data[0] = 32'hCAFE0001; bt_last[0] = 1'b1; bt_resp[0] = 2'b10;
    do_read("read_rresp_err", 32'h8000_0200, 8'd0, 1);

    accept_req(1'b1, 32'h8000_0204, 32'h1234_5678, 4'b1111, 8'd0, 1'b0);
    serve_write(32'h8000_0204, 32'h1234_5678, 4'b1111, 1, 2, 1, 2'b11, ID);
    check_idle("write_bresp_err");
    compare_resps("write_bresp_err");

    clear_beats();
    bt_data[0] = 32'hAAAA0000; bt_data[1] = 32'hAAAA0001; bt_last[1] = 1'b1;
    do_read("read_early_last", 32'h8000_0300, 8'd3, 1);

    // Reset in the middle of a four-beat burst after beat 1
    clear_beats();
    for (int i = 0; i < 4; i++) bt_data[i] = 32'hBB00_0000 + i;
    bt_last[3] = 1'b1;
    accept_req(1'b0, 32'h8000_0400, 32'd0, 4'd0, 8'd3, 1'b0);
    serve_read(32'h8000_0400, 8'd3, 0, 2, 0);
    exp_q.push_back({bt_data[0], 1'b0, 1'b0});
    exp_q.push_back({bt_data[1], 1'b0, 1'b0});
    reset  = 1'b0;
    rvalid = 1'b1; rdata = bt_data[2]; rlast = 1'b0; rresp = 2'b00; rid = ID;
    repeat (2) begin
      @(negedge clock);
      check("midrst_resp_valid", resp_valid, 0);
      check("midrst_rready", rready, 0);
      check("midrst_req_ready", req_ready, 0);
      step();
    end
    reset = 1'b1;
    @(negedge clock);
    check("midrst_rel_req_ready", req_ready, 1);
    check("midrst_rel_rready", rready, 0);
    check("midrst_rel_resp_valid", resp_valid, 0);
    step();
    rvalid = 1'b0;
    compare_resps("midrst");
    clear_beats();
    bt_data[0] = 32'h0BAD_F00D; bt_data[1] = 32'h600D_F00D; bt_last[1] = 1'b1;
    do_read("after_reset", 32'h8000_0500, 8'd1, 1);

    // Back-to-back: read then write with req_valid held high throughout
    clear_beats();
    bt_data[0] = 32'h5555_AAAA; bt_last[0] = 1'b1;
    n = model_read(0);
    accept_req(1'b0, 32'h8000_0600, 32'd0, 4'd0, 8'd0, 1'b1);
    req_wen = 1'b1; req_addr = 32'h8000_0604; req_wdata = 32'h0F0F_0F0F; req_wstrb = 4'b1100;
    serve_read(32'h8000_0600, 8'd0, 1, n, 2);
    rd_done = done_cyc;
    @(negedge clock);
    check("b2b_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    wr_acc = acc_cyc;
    check("b2b_accept_cycle", wr_acc, rd_done + 1);
    serve_write(32'h8000_0604, 32'h0F0F_0F0F, 4'b1100, 1, 1, 0, 2'b00, ID);
    check_idle("b2b");
    compare_resps("b2b");

    // Randomized mix of reads and writes
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 1) == 0) begin
        len = $urandom_range(0, 6);
        clear_beats();
        for (int i = 0; i <= len; i++) begin
          bt_data[i] = $urandom;
          bt_last[i] = (i == len);
          bt_resp[i] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          bt_id[i]   = ($urandom_range(0, 7) == 0) ? (ID ^ 4'h1) : ID;
        end
        if (len > 0 && $urandom_range(0, 3) == 0) bt_last[$urandom_range(0, len - 1)] = 1'b1;
        do_read("rand_read", {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 8'(len), 3);
      end else begin
        br   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        b_id = ($urandom_range(0, 5) == 0) ? (ID ^ 4'h2) : ID;
        req_addr  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        req_wdata = $urandom;
        req_wstrb = 4'($urandom_range(0, 15));
        accept_req(1'b1, req_addr, req_wdata, req_wstrb, 8'($urandom), 1'b0);
        serve_write(req_addr, req_wdata, req_wstrb, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), br, b_id);
        check_idle("rand_write");
        compare_resps("rand_write");
      end
    end

    check("ar_aw_overlap", overlap_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
